// File: rtl/chroni_mem_arbiter.sv
// Single-port video memory arbiter for chroni: video fetch vs CPU, one access at a time.
// Optional CPU fairness guard enabled by defining CHRONI_ARB_FAIRNESS_EN.
module chroni_mem_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int PAGE_W       = 8,
  parameter int MEM_LAT      = 1,
  parameter int CPU_MAX_WAIT = 8
) (
  input  logic                     sys_clk,
  input  logic                     reset,
  input  logic                     vid_req,
  input  logic [ADDR_W-1:0]        vid_addr,
  input  logic [PAGE_W-1:0]        vid_page,
  output logic                     vid_ack,
  output logic [7:0]               vid_data,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDR_W-1:0]        cpu_addr,
  input  logic [PAGE_W-1:0]        cpu_page,
  input  logic [7:0]               cpu_wdata,
  output logic                     cpu_ack,
  output logic [7:0]               cpu_rdata,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [PAGE_W+ADDR_W-1:0] mem_addr,
  output logic [7:0]               mem_wdata,
  input  logic [7:0]               mem_rdata,
  output logic                     busy
);

  localparam int MA_W = PAGE_W + ADDR_W;
  // Out-of-range configurations fall back to the minimum read latency.
  localparam bit CFG_OK = (MEM_LAT >= 1) && (MEM_LAT <= 7) &&
                          (CPU_MAX_WAIT >= 1) && (CPU_MAX_WAIT <= 15);
  localparam logic [2:0] LAT_LOAD = CFG_OK ? 3'(MEM_LAT) : 3'd1;

  typedef enum logic {S_IDLE, S_ACCESS} state_t;

  state_t state_q, state_d;
  logic [2:0] lat_cnt_q, lat_cnt_d;

  logic            vid_v_q, vid_v_d;
  logic [MA_W-1:0] vid_ma_q, vid_ma_d;
  logic            cpu_v_q, cpu_v_d;
  logic [MA_W-1:0] cpu_ma_q, cpu_ma_d;
  logic            cpu_we_q, cpu_we_d;
  logic [7:0]      cpu_wd_q, cpu_wd_d;

  logic            mem_en_q, mem_en_d;
  logic            mem_we_q, mem_we_d;
  logic [MA_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]      mem_wdata_q, mem_wdata_d;
  logic            vid_ack_q, vid_ack_d;
  logic [7:0]      vid_data_q, vid_data_d;
  logic            cpu_ack_q, cpu_ack_d;
  logic [7:0]      cpu_rdata_q, cpu_rdata_d;
  logic            own_cpu_q, own_cpu_d;
  logic            own_we_q, own_we_d;

  // A strobe is eligible at the edge it arrives, so an idle arbiter grants with no extra cycle.
  logic            vid_pend, cpu_pend;
  logic [MA_W-1:0] vid_ma, cpu_ma;
  logic            cpu_we_eff;
  logic [7:0]      cpu_wd_eff;
  logic            complete, can_grant, grant_vid, grant_cpu, grant_any, fair_trip;

  assign vid_pend   = vid_v_q | vid_req;
  assign vid_ma     = vid_v_q ? vid_ma_q : {vid_page, vid_addr};
  assign cpu_pend   = cpu_v_q | cpu_req;
  assign cpu_ma     = cpu_v_q ? cpu_ma_q : {cpu_page, cpu_addr};
  assign cpu_we_eff = cpu_v_q ? cpu_we_q : cpu_we;
  assign cpu_wd_eff = cpu_v_q ? cpu_wd_q : cpu_wdata;

  assign complete  = (state_q == S_ACCESS) && (lat_cnt_q == 3'd0);
  assign can_grant = (state_q == S_IDLE) || complete;
  assign grant_vid = can_grant & vid_pend & ~(fair_trip & cpu_pend);
  assign grant_cpu = can_grant & cpu_pend & ~grant_vid;
  assign grant_any = grant_vid | grant_cpu;

`ifdef CHRONI_ARB_FAIRNESS_EN
  localparam logic [3:0] WAIT_MAX = 4'(CPU_MAX_WAIT);
  logic [3:0] wait_cnt_q, wait_cnt_d;

  assign fair_trip = (wait_cnt_q == WAIT_MAX);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!cpu_pend || grant_cpu) begin
      wait_cnt_d = 4'd0;
    end else if (grant_vid) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end
`else
  assign fair_trip = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    lat_cnt_d = lat_cnt_q;
    if (grant_any) begin
      state_d   = S_ACCESS;
      lat_cnt_d = LAT_LOAD;
    end else if (complete) begin
      state_d = S_IDLE;
    end else if (state_q == S_ACCESS) begin
      lat_cnt_d = lat_cnt_q - 3'd1;
    end
  end

  always_comb begin
    vid_v_d     = vid_pend & ~grant_vid;
    vid_ma_d    = vid_ma;
    cpu_v_d     = cpu_pend & ~grant_cpu;
    cpu_ma_d    = cpu_ma;
    cpu_we_d    = cpu_we_eff;
    cpu_wd_d    = cpu_wd_eff;
    mem_en_d    = grant_any;
    mem_we_d    = grant_cpu & cpu_we_eff;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    own_cpu_d   = own_cpu_q;
    own_we_d    = own_we_q;
    if (grant_vid) begin
      mem_addr_d = vid_ma;
    end
    if (grant_cpu) begin
      mem_addr_d  = cpu_ma;
      mem_wdata_d = cpu_wd_eff;
    end
    if (grant_any) begin
      own_cpu_d = grant_cpu;
      own_we_d  = grant_cpu & cpu_we_eff;
    end
    vid_ack_d   = complete & ~own_cpu_q;
    cpu_ack_d   = complete & own_cpu_q;
    vid_data_d  = vid_ack_d ? mem_rdata : vid_data_q;
    cpu_rdata_d = (cpu_ack_d && !own_we_q) ? mem_rdata : cpu_rdata_q;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      lat_cnt_q   <= 3'd0;
      vid_v_q     <= 1'b0;
      vid_ma_q    <= '0;
      cpu_v_q     <= 1'b0;
      cpu_ma_q    <= '0;
      cpu_we_q    <= 1'b0;
      cpu_wd_q    <= 8'd0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= 8'd0;
      vid_ack_q   <= 1'b0;
      vid_data_q  <= 8'd0;
      cpu_ack_q   <= 1'b0;
      cpu_rdata_q <= 8'd0;
      own_cpu_q   <= 1'b0;
      own_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      lat_cnt_q   <= lat_cnt_d;
      vid_v_q     <= vid_v_d;
      vid_ma_q    <= vid_ma_d;
      cpu_v_q     <= cpu_v_d;
      cpu_ma_q    <= cpu_ma_d;
      cpu_we_q    <= cpu_we_d;
      cpu_wd_q    <= cpu_wd_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      vid_ack_q   <= vid_ack_d;
      vid_data_q  <= vid_data_d;
      cpu_ack_q   <= cpu_ack_d;
      cpu_rdata_q <= cpu_rdata_d;
      own_cpu_q   <= own_cpu_d;
      own_we_q    <= own_we_d;
    end
  end

  assign vid_ack   = vid_ack_q;
  assign vid_data  = vid_data_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_rdata = cpu_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q == S_ACCESS);

endmodule

// File: tb/tb_chroni_mem_arbiter.sv
// Self-checking bench for chroni_mem_arbiter: directed scenarios with literal checks,
// then random traffic compared every cycle against a timestamp-based reference model.
module tb_chroni_mem_arbiter;
  localparam int ADDR_W       = 13;
  localparam int PAGE_W       = 8;
  localparam int MEM_LAT      = 1;
  localparam int CPU_MAX_WAIT = 8;
  localparam int MA_W         = PAGE_W + ADDR_W;
`ifdef CHRONI_ARB_FAIRNESS_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif

  logic              sys_clk, reset;
  logic              vid_req, vid_ack, cpu_req, cpu_we, cpu_ack;
  logic [ADDR_W-1:0] vid_addr, cpu_addr;
  logic [PAGE_W-1:0] vid_page, cpu_page;
  logic [7:0]        vid_data, cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic              mem_en, mem_we, busy;
  logic [MA_W-1:0]   mem_addr;

  chroni_mem_arbiter #(
    .ADDR_W(ADDR_W), .PAGE_W(PAGE_W), .MEM_LAT(MEM_LAT), .CPU_MAX_WAIT(CPU_MAX_WAIT)
  ) dut (
    .sys_clk(sys_clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_page(vid_page),
    .vid_ack(vid_ack), .vid_data(vid_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_page(cpu_page),
    .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int     vectors = 0;
  int     miscompares = 0;
  longint cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- RAM model (one registered read stage) ----------------
  logic [7:0] ram_mem [int];
  logic [7:0] mdl_mem [int];

  initial mem_rdata = 8'h00;

  always @(posedge sys_clk) begin : ram_model
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) ram_mem[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram_mem.exists(int'(mem_addr)) ? ram_mem[int'(mem_addr)] : 8'h00;
    end
  end

  function automatic logic [7:0] mdl_rd(input logic [MA_W-1:0] a);
    return mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : 8'h00;
  endfunction

  task automatic preload(input logic [MA_W-1:0] a, input logic [7:0] d);
    ram_mem[int'(a)] = d;
    mdl_mem[int'(a)] = d;
  endtask

  // ---------------- reference model ----------------
  // The in-flight access is a record with a completion timestamp; pending requests are
  // one-entry slots; the CPU age counter is "video grants since CPU became pending".
  bit              m_vid_v, m_cpu_v, m_cpu_we, m_busy, m_own_cpu, m_own_we;
  logic [MA_W-1:0] m_vid_a, m_cpu_a;
  logic [7:0]      m_cpu_wd, m_rd;
  longint          m_done;
  int              m_waits;
  logic            e_vid_ack = 0, e_cpu_ack = 0, e_mem_en = 0, e_mem_we = 0, e_busy = 0;
  logic [7:0]      e_vid_data = 0, e_cpu_rdata = 0, e_mem_wdata = 0;
  logic [MA_W-1:0] e_mem_addr = 0;

  always @(posedge sys_clk) begin : model
    bit vp, cp, free, tv, tc, cwe;
    logic [MA_W-1:0] va, ca;
    logic [7:0] cwd;
    cyc++;
    if (reset) begin
      m_vid_v = 0; m_cpu_v = 0; m_busy = 0; m_waits = 0;
      e_vid_ack = 0; e_cpu_ack = 0; e_mem_en = 0; e_mem_we = 0; e_busy = 0;
      e_vid_data = 0; e_cpu_rdata = 0; e_mem_wdata = 0; e_mem_addr = 0;
    end else begin
      e_vid_ack = 0; e_cpu_ack = 0; e_mem_en = 0; e_mem_we = 0;
      free = !m_busy;
      if (m_busy && cyc == m_done) begin
        if (m_own_cpu) begin
          e_cpu_ack = 1;
          if (!m_own_we) e_cpu_rdata = m_rd;
        end else begin
          e_vid_ack = 1;
          e_vid_data = m_rd;
        end
        m_busy = 0;
        free = 1;
      end
      vp  = m_vid_v || vid_req;
      va  = m_vid_v ? m_vid_a : {vid_page, vid_addr};
      cp  = m_cpu_v || cpu_req;
      ca  = m_cpu_v ? m_cpu_a : {cpu_page, cpu_addr};
      cwe = m_cpu_v ? m_cpu_we : cpu_we;
      cwd = m_cpu_v ? m_cpu_wd : cpu_wdata;
      tc  = free && cp && (!vp || (FAIR && m_waits == CPU_MAX_WAIT));
      tv  = free && vp && !tc;
      if (tv) begin
        e_mem_addr = va;
        m_rd = mdl_rd(va);
        m_own_cpu = 0; m_own_we = 0;
      end
      if (tc) begin
        e_mem_addr = ca;
        e_mem_wdata = cwd;
        e_mem_we = cwe;
        if (cwe) mdl_mem[int'(ca)] = cwd;
        else m_rd = mdl_rd(ca);
        m_own_cpu = 1; m_own_we = cwe;
      end
      if (tv || tc) begin
        e_mem_en = 1;
        m_busy = 1;
        m_done = cyc + MEM_LAT + 1;
      end
      m_vid_v = vp && !tv;  m_vid_a = va;
      m_cpu_v = cp && !tc;  m_cpu_a = ca; m_cpu_we = cwe; m_cpu_wd = cwd;
      if (!cp || tc) m_waits = 0;
      else if (tv) m_waits++;
      e_busy = m_busy;
    end
  end

  // ---------------- scoreboard: every-cycle compare ----------------
  always @(posedge sys_clk) begin : compare
    #1;
    chk("vid_ack",   {31'd0, vid_ack},   {31'd0, e_vid_ack});
    chk("vid_data",  {24'd0, vid_data},  {24'd0, e_vid_data});
    chk("cpu_ack",   {31'd0, cpu_ack},   {31'd0, e_cpu_ack});
    chk("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, e_cpu_rdata});
    chk("mem_en",    {31'd0, mem_en},    {31'd0, e_mem_en});
    chk("mem_we",    {31'd0, mem_we},    {31'd0, e_mem_we});
    chk("mem_addr",  {11'd0, mem_addr},  {11'd0, e_mem_addr});
    chk("mem_wdata", {24'd0, mem_wdata}, {24'd0, e_mem_wdata});
    chk("busy",      {31'd0, busy},      {31'd0, e_busy});
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic idle_inputs();
    vid_req = 0; cpu_req = 0; cpu_we = 0;
  endtask

  task automatic idle(input int n);
    idle_inputs();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic set_vid(input logic [PAGE_W-1:0] p, input logic [ADDR_W-1:0] a);
    vid_req = 1; vid_page = p; vid_addr = a;
  endtask

  task automatic set_cpu(input logic we, input logic [PAGE_W-1:0] p,
                         input logic [ADDR_W-1:0] a, input logic [7:0] d);
    cpu_req = 1; cpu_we = we; cpu_page = p; cpu_addr = a; cpu_wdata = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin : stim
    int  vg;
    int  bad_cnt;
    int  ack_cnt;
    bit  cpu_seen;
    bit  burst;
    reset = 1; vid_addr = 0; vid_page = 0; cpu_addr = 0; cpu_page = 0; cpu_wdata = 0;
    idle_inputs();
    preload(21'h00403, 8'h41);
    preload(21'h00010, 8'h11);
    preload(21'h00020, 8'h22);
    preload(21'h02100, 8'h3B);
    preload(21'h02200, 8'h5C);
    tick(); tick(); tick();
    chk("reset_mem_en", {31'd0, mem_en}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 0;
    idle(2);

    // 1: single video read
    set_vid(8'h00, 13'h0403);
    tick(); idle_inputs();
    chk("t1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("t1_mem_addr", {11'd0, mem_addr}, 32'h00403);
    tick();
    chk("t1_busy_mid", {31'd0, busy}, 32'd1);
    tick();
    chk("t1_vid_ack", {31'd0, vid_ack}, 32'd1);
    chk("t1_vid_data", {24'd0, vid_data}, 32'h41);
    tick();
    chk("t1_busy_after", {31'd0, busy}, 32'd0);
    chk("t1_ack_pulse", {31'd0, vid_ack}, 32'd0);
    idle(3);

    // 2: simultaneous strobes, video first
    set_vid(8'h00, 13'h0010);
    set_cpu(1'b0, 8'h00, 13'h0020, 8'h00);
    tick(); idle_inputs();
    chk("t2_vid_grant", {11'd0, mem_addr}, 32'h00010);
    tick(); tick();
    chk("t2_vid_ack", {31'd0, vid_ack}, 32'd1);
    chk("t2_vid_data", {24'd0, vid_data}, 32'h11);
    chk("t2_cpu_grant_en", {31'd0, mem_en}, 32'd1);
    chk("t2_cpu_grant_addr", {11'd0, mem_addr}, 32'h00020);
    tick();
    chk("t2_cpu_ack_early", {31'd0, cpu_ack}, 32'd0);
    tick();
    chk("t2_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    chk("t2_cpu_rdata", {24'd0, cpu_rdata}, 32'h22);
    idle(3);

    // 3: CPU write then read-back
    set_cpu(1'b1, 8'h02, 13'h0010, 8'hA5);
    tick(); idle_inputs();
    chk("t3_mem_we", {31'd0, mem_we}, 32'd1);
    chk("t3_mem_addr", {11'd0, mem_addr}, 32'h04010);
    chk("t3_mem_wdata", {24'd0, mem_wdata}, 32'hA5);
    tick();
    chk("t3_mem_we_pulse", {31'd0, mem_we}, 32'd0);
    tick();
    chk("t3_cpu_ack", {31'd0, cpu_ack}, 32'd1);
    chk("t3_rdata_kept", {24'd0, cpu_rdata}, 32'h22);
    set_cpu(1'b0, 8'h02, 13'h0010, 8'h00);
    tick(); idle_inputs(); tick(); tick();
    chk("t3_readback", {24'd0, cpu_rdata}, 32'hA5);
    idle(3);

    // 4: video keeps re-strobing while a CPU read waits
    vg = 0; cpu_seen = 0;
    for (int t = 0; t < 40; t++) begin
      vid_req = (t <= 23); vid_page = 8'h01; vid_addr = 13'h0100;
      cpu_req = (t == 1); cpu_we = 0; cpu_page = 8'h01; cpu_addr = 13'h0200;
      tick();
      if (mem_en === 1'b1 && !cpu_seen) begin
        if (mem_addr === 21'h02200) cpu_seen = 1;
        else vg++;
      end
    end
    chk("t4_cpu_granted", {31'd0, cpu_seen}, 32'd1);
    chk("t4_vid_grants_before_cpu", vg, FAIR ? 32'd9 : 32'd13);
    chk("t4_vid_data", {24'd0, vid_data}, 32'h3B);
    chk("t4_cpu_rdata", {24'd0, cpu_rdata}, 32'h5C);
    idle(3);

    // 5: reset in the cycle after mem_en
    set_vid(8'h00, 13'h0010);
    tick();
    reset = 1; set_vid(8'h00, 13'h0020);
    tick();
    reset = 0; idle_inputs();
    chk("t5_vid_data", {24'd0, vid_data}, 32'd0);
    chk("t5_cpu_rdata", {24'd0, cpu_rdata}, 32'd0);
    chk("t5_mem_addr", {11'd0, mem_addr}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd0);
    ack_cnt = 0;
    for (int t = 0; t < 4; t++) begin
      tick();
      if (vid_ack === 1'b1 || mem_en === 1'b1) ack_cnt++;
    end
    chk("t5_no_ack_or_grant", ack_cnt, 32'd0);
    set_vid(8'h00, 13'h0403);
    tick(); idle_inputs(); tick(); tick();
    chk("t5_fresh_ack", {31'd0, vid_ack}, 32'd1);
    chk("t5_fresh_data", {24'd0, vid_data}, 32'h41);
    idle(3);

    // 6: duplicate video strobe while its slot is pending
    set_cpu(1'b0, 8'h00, 13'h0030, 8'h00);
    tick(); idle_inputs();
    set_vid(8'h00, 13'h0040);
    tick();
    set_vid(8'h00, 13'h0050);
    tick(); idle_inputs();
    chk("t6_first_addr", {11'd0, mem_addr}, 32'h00040);
    bad_cnt = 0; ack_cnt = 0;
    for (int t = 0; t < 6; t++) begin
      tick();
      if (mem_en === 1'b1 && mem_addr === 21'h00050) bad_cnt++;
      if (vid_ack === 1'b1) ack_cnt++;
    end
    chk("t6_dup_dropped", bad_cnt, 32'd0);
    chk("t6_one_vid_ack", ack_cnt, 32'd1);
    idle(3);

    // random traffic, with video bursts to exercise the priority/fairness path
    burst = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) burst = ($urandom_range(0, 1) == 1);
      reset     = ($urandom_range(0, 399) == 0);
      vid_req   = burst ? 1'b1 : ($urandom_range(0, 3) == 0);
      vid_page  = 8'($urandom_range(0, 3));
      vid_addr  = 13'($urandom_range(0, 15));
      cpu_req   = ($urandom_range(0, 3) == 0);
      cpu_we    = ($urandom_range(0, 1) == 1);
      cpu_page  = 8'($urandom_range(0, 3));
      cpu_addr  = 13'($urandom_range(0, 15));
      cpu_wdata = 8'($urandom_range(0, 255));
      tick();
    end
    reset = 0;
    idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
